// File: rtl/ld_st_bus_ctrl_if.sv
// External memory bus between the load/store controller (master) and a memory
// responder (slave): four-phase req/ack handshake with registered request side.
interface ld_st_bus_ctrl_if #(
  parameter int n = 8,
  parameter int a = 8
) ();
  logic         mem_req;
  logic         mem_we;
  logic [a-1:0] mem_addr;
  logic [n-1:0] mem_wdata;
  logic [n-1:0] mem_rdata;
  logic         mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/ld_st_bus_ctrl.sv
// Load/store bus controller: runs one datapath load or store on the external
// memory bus via a four-phase req/ack handshake, bounded by an ack timeout.
module ld_st_bus_ctrl #(
  parameter int n   = 8,
  parameter int a   = 8,
  parameter int TMO = 15
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             ldStr,
  input  logic [a-1:0]     addr_in,
  input  logic [n-1:0]     wdata_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [n-1:0]     rdata,
  ld_st_bus_ctrl_if.master mem
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RELEASE,
    DONE
  } state_t;

  // The counter holds the number of ack-less REQ edges seen so far; the edge
  // that would bring it to TMO is the timeout edge, so REQ lasts TMO cycles.
  localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

  state_t       state, state_nx;
  logic [7:0]   cnt, cnt_nx;
  logic         err_nx, busy_nx, done_nx, req_nx, we_nx;
  logic [n-1:0] rdata_nx, wdata_nx;
  logic [a-1:0] addr_nx;
  logic         timeout;

  // Ack on the timeout edge takes priority, so timeout requires ack low.
  assign timeout = (cnt == TMO_LAST) && !mem.mem_ack;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = REQ;
      REQ:     if (mem.mem_ack || timeout) state_nx = RELEASE;
      RELEASE: if (!mem.mem_ack) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cnt_nx   = cnt;
    err_nx   = err;
    rdata_nx = rdata;
    we_nx    = mem.mem_we;
    addr_nx  = mem.mem_addr;
    wdata_nx = mem.mem_wdata;
    case (state)
      IDLE: begin
        if (start) begin
          we_nx    = ldStr;
          addr_nx  = addr_in;
          wdata_nx = wdata_in;
          err_nx   = 1'b0;
          cnt_nx   = '0;
        end
      end
      REQ: begin
        if (mem.mem_ack) begin
          if (!mem.mem_we) rdata_nx = mem.mem_rdata;
        end else begin
          cnt_nx = cnt + 8'd1;
          if (cnt == TMO_LAST) err_nx = 1'b1;
        end
      end
      default: ;
    endcase
    busy_nx = (state_nx != IDLE);
    done_nx = (state_nx == DONE);
    req_nx  = (state_nx == REQ);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      rdata         <= '0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
    end else begin
      cnt           <= cnt_nx;
      busy          <= busy_nx;
      done          <= done_nx;
      err           <= err_nx;
      rdata         <= rdata_nx;
      mem.mem_req   <= req_nx;
      mem.mem_we    <= we_nx;
      mem.mem_addr  <= addr_nx;
      mem.mem_wdata <= wdata_nx;
    end
  end

endmodule
